udma_evt_arbiter: RTL

Collects single-cycle event pulses from N uDMA peripherals and channels and serialises them into one valid/ready event stream. The stream feeds the uDMA control block's event comparator input (event_valid/event_data/event_ready). Each source has a saturating pending counter, so bursts are not lost. Sources are served round-robin, and every event is tagged with an 8-bit event ID.

---
 rtl/udma_evt_pkg.sv | 13 +
 rtl/udma_evt_pending_cnt.sv | 39 +++
 rtl/udma_evt_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/udma_evt_pkg.sv
// Shared constants and helpers for the uDMA event arbiter slice.
// Event IDs are formed as base + source index and wrap at the event width.
package udma_evt_pkg;

    localparam int UDMA_EVT_W     = 8;
    localparam int UDMA_EVT_CNT_W = 2;

    // Full-width sum; the caller truncates to its event width, which gives the wrap
    function automatic logic [31:0] evt_id(input logic [31:0] base, input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/udma_evt_pending_cnt.sv
// Per-source saturating pending counter: up on an event, down when the source is
// granted into the output register, cleared while the source is disabled.
module udma_evt_pending_cnt
    import udma_evt_pkg::*;
#(
    parameter int CNT_W = UDMA_EVT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic nz,
    output logic ovf_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic             at_max;

    assign at_max    = (cnt == CNT_MAX);
    assign nz        = |cnt;
    // A simultaneous grant makes room, so inc+dec at max is not an overflow
    assign ovf_pulse = inc & ~dec & at_max & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && nz) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/udma_evt_arbiter.sv
// Serialises per-source event pulses into one valid/ready event stream with
// round-robin service and a single registered output stage.
module udma_evt_arbiter
    import udma_evt_pkg::*;
#(
    parameter int N_SRC    = 8,
    parameter int EVT_W    = UDMA_EVT_W,
    parameter int CNT_W    = UDMA_EVT_CNT_W,
    parameter int EVT_BASE = 0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N_SRC-1:0] evt_src_i,
    input  logic [N_SRC-1:0] cfg_en_i,
    input  logic [N_SRC-1:0] ovf_clr_i,
    output logic [N_SRC-1:0] ovf_o,
    output logic             event_valid_o,
    output logic [EVT_W-1:0] event_data_o,
    input  logic             event_ready_i
);

    localparam int PTR_W = $clog2(N_SRC);

    logic [N_SRC-1:0] nz;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] dec;
    logic [N_SRC-1:0] ovf_set;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant;
    logic             any;
    logic             can_load;
    logic             load;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        udma_evt_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk_i),
            .rst_n     (rstn_i),
            .clr       (~cfg_en_i[i]),
            .inc       (evt_src_i[i] & cfg_en_i[i]),
            .dec       (dec[i]),
            .nz        (nz[i]),
            .ovf_pulse (ovf_set[i])
        );
    end

    // A source being disabled this cycle is not granted: its count is being flushed
    assign req      = nz & cfg_en_i;
    assign any      = |req;
    assign can_load = ~event_valid_o | event_ready_i;
    assign load     = can_load & any;

    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N_SRC; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        dec = '0;
        if (load) dec[grant] = 1'b1;
    end

    // event_valid_o is the EMPTY/FULL state of the output stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_o         <= '0;
            event_valid_o <= 1'b0;
            event_data_o  <= '0;
            ptr           <= '0;
        end else begin
            ovf_o <= (ovf_o & ~ovf_clr_i) | ovf_set;
            if (can_load) begin
                event_valid_o <= any;
                if (any) begin
                    event_data_o <= EVT_W'(evt_id(32'(EVT_BASE), 32'(grant)));
                    ptr          <= (int'(grant) == N_SRC - 1) ? '0 : grant + PTR_W'(1);
                end
            end
        end
    end

endmodule
